// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter: iterative AES-128/192/256 key expansion into a local round-key store (optional wipe: AES_KS_ZEROIZE_EN).
// Latency: schedule complete 50/54/65 cycles after key accept; round-key read data registered, 1 cycle.
// Backpressure: key_ready only while IDLE; oversize key_len offers are consumed with a key_err pulse.
module aes_key_sched_iter #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef AES_KS_ZEROIZE_EN
  input  logic                    zeroize,
`endif
  input  logic [MAX_KEY_BITS-1:0] key_in,
  input  logic [1:0]              key_len,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic                    key_err,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              nr,
  input  logic [3:0]              rd_idx,
  output logic [127:0]            rd_data,
  output logic                    rd_err
);
  localparam int DEPTH = (MAX_KEY_BITS == 128) ? 44 : (MAX_KEY_BITS == 192) ? 52 : 60;
  localparam int MAX_NK = MAX_KEY_BITS / 32;
  localparam logic [3:0] LAST_RK = 4'(DEPTH / 4 - 1);

`ifdef AES_KS_ZEROIZE_EN
  typedef enum logic [1:0] {S_IDLE, S_GEN_S, S_GEN_W, S_WIPE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GEN_S, S_GEN_W} state_t;
`endif

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_words [DEPTH];
  logic [5:0]    r_idx;
  logic [2:0]    r_pos;      // i mod Nk, tracked incrementally since Nk=6 is not a power of two
  logic [3:0]    r_nk;
  logic [7:0]    r_rcon;
  logic [31:0]   r_sub;
  logic [3:0]    r_nr;
  logic          r_done;
  logic          r_key_err;
  logic [127:0]  r_rd_data;
  logic          r_rd_err;

  logic          w_zero, w_offer, w_len_bad, w_accept, w_need_sub, w_need_sub_nxt, w_last, w_rd_ok;
  logic [2:0]    w_pos_nxt;
  logic [3:0]    w_nk_in;
  logic [5:0]    w_rd_base;
  logic [31:0]   w_prev, w_back, w_s_in, w_s_out, w_new;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t, r;
    t = a;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

`ifdef AES_KS_ZEROIZE_EN
  assign w_zero = zeroize;
`else
  assign w_zero = 1'b0;
`endif

  assign w_offer   = key_valid && (r_state == S_IDLE) && !w_zero;
  assign w_len_bad = ((key_len == 2'd2) && (MAX_KEY_BITS < 256)) ||
                     ((key_len == 2'd1) && (MAX_KEY_BITS < 192));
  assign w_accept  = w_offer && !w_len_bad;
  assign w_nk_in   = (key_len == 2'd1) ? 4'd6 : (key_len == 2'd2) ? 4'd8 : 4'd4;

  assign w_prev         = r_words[r_idx - 6'd1];
  assign w_back         = r_words[r_idx - {2'b00, r_nk}];
  assign w_need_sub     = (r_pos == 3'd0) || ((r_nk == 4'd8) && (r_pos == 3'd4));
  assign w_pos_nxt      = (r_pos == 3'(r_nk - 4'd1)) ? 3'd0 : r_pos + 3'd1;
  assign w_need_sub_nxt = (w_pos_nxt == 3'd0) || ((r_nk == 4'd8) && (w_pos_nxt == 3'd4));
  assign w_last         = (r_idx == {r_nr, 2'b11});
  assign w_s_in         = (r_pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_s_out        = {sbox(w_s_in[31:24]), sbox(w_s_in[23:16]), sbox(w_s_in[15:8]), sbox(w_s_in[7:0])};
  assign w_new          = w_need_sub ? (w_back ^ r_sub ^ ((r_pos == 3'd0) ? {r_rcon, 24'h0} : 32'h0))
                                     : (w_back ^ w_prev);

  // Next state: SubWord words spend one cycle in GEN_S, every word is written in GEN_W
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_GEN_S;
      S_GEN_S: w_state_nxt = S_GEN_W;
      S_GEN_W: begin
        if (w_last)              w_state_nxt = S_IDLE;
        else if (w_need_sub_nxt) w_state_nxt = S_GEN_S;
        else                     w_state_nxt = S_GEN_W;
      end
`ifdef AES_KS_ZEROIZE_EN
      S_WIPE:  if (r_idx == 6'(DEPTH - 1)) w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef AES_KS_ZEROIZE_EN
    if (zeroize) w_state_nxt = S_WIPE;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Expansion control: word index, position within Nk, rcon, registered S-box result, status
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= 6'd0;
      r_pos     <= 3'd0;
      r_nk      <= 4'd4;
      r_rcon    <= 8'h01;
      r_sub     <= 32'h0;
      r_nr      <= 4'd0;
      r_done    <= 1'b0;
      r_key_err <= 1'b0;
    end else begin
      r_key_err <= w_offer && w_len_bad;
      if (w_zero) begin
        r_idx  <= 6'd0;
        r_done <= 1'b0;
        r_nr   <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: if (w_accept) begin
            r_idx  <= {2'b00, w_nk_in};
            r_pos  <= 3'd0;
            r_nk   <= w_nk_in;
            r_rcon <= 8'h01;
            r_nr   <= w_nk_in + 4'd6;
            r_done <= 1'b0;
          end
          S_GEN_S: r_sub <= w_s_out;
          S_GEN_W: begin
            r_idx <= r_idx + 6'd1;
            r_pos <= w_pos_nxt;
            if (r_pos == 3'd0) r_rcon <= xtime(r_rcon);
            if (w_last)        r_done <= 1'b1;
          end
`ifdef AES_KS_ZEROIZE_EN
          S_WIPE: r_idx <= r_idx + 6'd1;
`endif
          default: ;
        endcase
      end
    end
  end

  // Word storage: key words on accept, one generated (or wiped) word per GEN_W/WIPE cycle; never reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_accept) begin
        for (int j = 0; j < MAX_NK; j++)
          if (j < int'(w_nk_in)) r_words[j] <= key_in[MAX_KEY_BITS-1-32*j -: 32];
      end else if (r_state == S_GEN_W) begin
        r_words[r_idx] <= w_new;
      end
`ifdef AES_KS_ZEROIZE_EN
      else if (r_state == S_WIPE) begin
        r_words[r_idx] <= 32'h0;
      end
`endif
    end
  end

  assign w_rd_ok   = r_done && (rd_idx <= r_nr);
  assign w_rd_base = {(rd_idx <= LAST_RK) ? rd_idx : 4'd0, 2'b00};

  // Registered round-key read port; zero data and error whenever the schedule is not complete
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= 128'h0;
      r_rd_err  <= 1'b0;
    end else begin
      r_rd_data <= w_rd_ok ? {r_words[w_rd_base], r_words[w_rd_base + 6'd1],
                              r_words[w_rd_base + 6'd2], r_words[w_rd_base + 6'd3]} : 128'h0;
      r_rd_err  <= !w_rd_ok;
    end
  end

  assign key_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign nr        = r_nr;
  assign key_err   = r_key_err;
  assign rd_data   = r_rd_data;
  assign rd_err    = r_rd_err;
endmodule

// File: tb/tb_aes_key_sched_iter.sv
// tb_aes_key_sched_iter: scoreboard bench for aes_key_sched_iter against a FIPS-197 style reference expansion.
// Latency: read expectations are queued with their capture cycle and popped by a negedge monitor.
// Backpressure: keys are offered only while key_ready; a MAX_KEY_BITS=128 instance covers oversize key_len.
`timescale 1ns/1ps
module tb_aes_key_sched_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [255:0] key_in = '0;
  logic [1:0]   key_len = 2'd0;
  logic         key_valid = 1'b0;
  logic         key_ready, key_err, busy, done, rd_err;
  logic [3:0]   nr;
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_data;

  logic [127:0] k_key_in = '0;
  logic [1:0]   k_key_len = 2'd0;
  logic         k_key_valid = 1'b0;
  logic         k_key_ready, k_key_err, k_busy, k_done, k_rd_err;
  logic [3:0]   k_nr;
  logic [3:0]   k_rd_idx = 4'd0;
  logic [127:0] k_rd_data;
`ifdef AES_KS_ZEROIZE_EN
  logic zeroize = 1'b0;
  logic k_zeroize = 1'b0;
`endif

  aes_key_sched_iter #(.MAX_KEY_BITS(256)) u_dut (
    .clk(clk), .reset(reset),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_in(key_in), .key_len(key_len), .key_valid(key_valid), .key_ready(key_ready),
    .key_err(key_err), .busy(busy), .done(done), .nr(nr),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_err(rd_err)
  );

  aes_key_sched_iter #(.MAX_KEY_BITS(128)) u_dut128 (
    .clk(clk), .reset(reset),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(k_zeroize),
`endif
    .key_in(k_key_in), .key_len(k_key_len), .key_valid(k_key_valid), .key_ready(k_key_ready),
    .key_err(k_key_err), .busy(k_busy), .done(k_done), .nr(k_nr),
    .rd_idx(k_rd_idx), .rd_data(k_rd_data), .rd_err(k_rd_err)
  );

  int cyc = 0;
  // Cycle counter used to tag read expectations with their capture edge
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int t_acc   = 0;

  typedef struct { int t; logic [127:0] data; logic err; } exp_t;
  exp_t q[$];
  exp_t me;

  logic [7:0]  sb [256];
  logic [31:0] m_w [60];
  int          m_nr = 0;
  bit          m_valid = 1'b0;

  localparam logic [127:0] K128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Polynomial product then reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] r = 8'h01;
    for (int k = 1; k < n; k++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic expand(input logic [255:0] key, input logic [1:0] len);
    int nk;
    logic [31:0] t;
    nk = (len == 2'd1) ? 6 : (len == 2'd2) ? 8 : 4;
    m_nr = nk + 6;
    for (int i = 0; i < nk; i++) m_w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (m_nr + 1); i++) begin
      t = m_w[i-1];
      if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4) t = sub_word(t);
      m_w[i] = m_w[i-nk] ^ t;
    end
  endtask

  task automatic issue_rd_exp(input logic [3:0] idx, input logic [127:0] d, input logic e);
    exp_t x;
    rd_idx = idx;
    x.t = cyc + 1;
    x.data = d;
    x.err = e;
    q.push_back(x);
    tick();
  endtask

  task automatic issue_rd(input logic [3:0] idx);
    int i;
    i = int'(idx);
    if (m_valid && i <= m_nr) issue_rd_exp(idx, {m_w[4*i], m_w[4*i+1], m_w[4*i+2], m_w[4*i+3]}, 1'b0);
    else                      issue_rd_exp(idx, 128'h0, 1'b1);
  endtask

  task automatic load_key(input logic [255:0] key, input logic [1:0] len);
    key_in = key;
    key_len = len;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    t_acc = cyc;
    m_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_done_low", done, 0);
    check("accept_ready_low", key_ready, 0);
  endtask

  task automatic run_key(input logic [255:0] key, input logic [1:0] len, input int exp_n);
    int n;
    expand(key, len);
    load_key(key, len);
    for (int k = 0; k < 5; k++) issue_rd(4'($urandom_range(0, 15)));
    n = -1;
    for (int k = 0; k < 300 && n < 0; k++) begin
      tick();
      if (done) n = cyc - t_acc;
    end
    if (n < 0) check("done_timeout", 0, 1);
    else       check("done_latency", n, exp_n);
    m_valid = 1'b1;
    check("nr", nr, m_nr);
    check("idle_after_done", {busy, key_ready}, 2'b01);
    for (int r = 0; r < 16; r++) issue_rd(4'(r));
    for (int k = 0; k < 6; k++) issue_rd(4'($urandom_range(0, 15)));
  endtask

  // Scoreboard monitor: pops each read expectation on the cycle its data is registered
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].t <= cyc) begin
      me = q.pop_front();
      if (me.t < cyc) begin
        check("rd_missed", 128'(cyc), 128'(me.t));
      end else begin
        check("rd_data", rd_data, me.data);
        check("rd_err", rd_err, me.err);
      end
    end
  end

  initial begin
    int n;
    build_sbox();
    tick(); tick(); tick();
    check("rst_ready", key_ready, 1);
    check("rst_busy_done", {busy, done, key_err}, 3'b000);
    check("rst_nr", nr, 0);
    check("rst_rd", {rd_data, rd_err}, 129'h0);
    reset = 1'b0;
    issue_rd(4'd0);

    // Known-answer vectors, each loaded while the previous schedule is done
    run_key({K128, 128'($urandom)}, 2'd0, 50);
    issue_rd_exp(4'd0, K128, 1'b0);
    issue_rd_exp(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b0);
    run_key({K192, 64'($urandom)}, 2'd1, 54);
    issue_rd_exp(4'd12, 128'he98ba06f_448c773c_8ecc7204_01002202, 1'b0);
    run_key(K256, 2'd2, 65);
    issue_rd_exp(4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e, 1'b0);
    issue_rd_exp(4'd15, 128'h0, 1'b1);

    // Reset 20 cycles into an AES-256 expansion, then AES-128 must still work
    expand(K256, 2'd2);
    load_key(K256, 2'd2);
    for (int k = 0; k < 19; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_valid = 1'b0;
    check("abort_state", {busy, done, key_ready}, 3'b001);
    check("abort_nr", nr, 0);
    run_key({K128, 128'($urandom)}, 2'd0, 50);
    issue_rd_exp(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b0);

    // Random keys and lengths, key_len=3 behaving as 128
    for (int r = 0; r < 6; r++) begin
      logic [255:0] kr;
      logic [1:0] lr;
      for (int w = 0; w < 8; w++) kr[32*w +: 32] = $urandom;
      lr = 2'($urandom_range(0, 3));
      run_key(kr, lr, (lr == 2'd1) ? 54 : (lr == 2'd2) ? 65 : 50);
    end

`ifdef AES_KS_ZEROIZE_EN
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    m_valid = 1'b0;
    n = 0;
    while (busy && !done && n < 100) begin
      n++;
      tick();
    end
    check("wipe_cycles", n, 60);
    check("wipe_end", {busy, done, key_ready}, 3'b001);
    issue_rd(4'd0);
    issue_rd_exp(4'd0, 128'h0, 1'b1);
`endif

    // Oversize key_len on the 128-bit instance after a completed schedule
    k_key_in = K128;
    k_key_len = 2'd0;
    k_key_valid = 1'b1;
    tick();
    k_key_valid = 1'b0;
    t_acc = cyc;
    n = -1;
    for (int k = 0; k < 300 && n < 0; k++) begin
      tick();
      if (k_done) n = cyc - t_acc;
    end
    check("k_done_latency", n, 50);
    check("k_nr", k_nr, 10);
    for (int l = 1; l <= 2; l++) begin
      k_key_len = 2'(l);
      k_key_valid = 1'b1;
      tick();
      k_key_valid = 1'b0;
      check("k_err_pulse", k_key_err, 1);
      check("k_err_state", {k_busy, k_done, k_key_ready}, 3'b011);
      check("k_err_nr", k_nr, 10);
      tick();
      check("k_err_clear", {k_key_err, k_busy, k_done}, 3'b001);
    end

    tick(); tick();
    check("queue_drain", 128'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
